mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_if.sv | 25 ++
 rtl/mul_sequencer.sv | 112 +++++++++++
 tb/tb_mul_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Multiply-sequencer request/writeback bundle between the pipeline (master) and the
// iterative multiplier (slave).
interface mul_sequencer_if;
   logic        Start;
   logic        Signed;
   logic        Long;
   logic        Flush;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Busy;
   logic        WbValid;
   logic        AuxW;
   logic        Done;
   logic [31:0] WbData;

   modport master (
      output Start, Signed, Long, Flush, SrcA, SrcB,
      input  Busy, WbValid, AuxW, Done, WbData
   );

   modport slave (
      input  Start, Signed, Long, Flush, SrcA, SrcB,
      output Busy, WbValid, AuxW, Done, WbData
   );
endinterface

// File: rtl/mul_sequencer.sv
// 32x32 radix-2 shift-add multiplier with MUL/UMULL/SMULL writeback sequencing.
// Operates on magnitudes and negates the 64-bit accumulator at the end for signed results.
module mul_sequencer (
   input logic             clk,
   input logic             reset,
   mul_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

   state_t      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic        long_q, long_d;
   logic        sign_q, sign_d;
   logic        busy_q, busy_d;
   logic        wb_valid_q, wb_valid_d;
   logic        aux_w_q, aux_w_d;
   logic        done_q, done_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic [31:0] mag_a, mag_b;
   logic [63:0] prod;

   always_comb begin
      mag_a = (bus.Signed && bus.SrcA[31]) ? (~bus.SrcA + 32'd1) : bus.SrcA;
      mag_b = (bus.Signed && bus.SrcB[31]) ? (~bus.SrcB + 32'd1) : bus.SrcB;
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      long_d   = long_q;
      sign_d   = sign_q;

      case (state_q)
         IDLE: begin
            if (bus.Start && !bus.Flush) begin
               mcand_d  = mag_a;
               mplier_d = mag_b;
               long_d   = bus.Long;
               sign_d   = bus.Signed & (bus.SrcA[31] ^ bus.SrcB[31]);
               acc_d    = 64'd0;
               cnt_d    = 5'd0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[cnt_q]) acc_d = acc_q + (64'(mcand_q) << cnt_q);
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = WB_LO;
         end
         WB_LO:   state_d = long_q ? WB_HI : IDLE;
         WB_HI:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (bus.Flush && (state_q != IDLE)) state_d = IDLE;

      // Outputs are registered from the next state so they line up with it.
      prod       = sign_q ? (~acc_d + 64'd1) : acc_d;
      busy_d     = (state_d != IDLE);
      wb_valid_d = (state_d == WB_LO) || (state_d == WB_HI);
      aux_w_d    = (state_d == WB_HI);
      done_d     = ((state_d == WB_LO) && !long_d) || (state_d == WB_HI);
      wb_data_d  = 32'd0;
      if (state_d == WB_LO)      wb_data_d = prod[31:0];
      else if (state_d == WB_HI) wb_data_d = prod[63:32];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= 64'd0;
         cnt_q      <= 5'd0;
         mcand_q    <= 32'd0;
         mplier_q   <= 32'd0;
         long_q     <= 1'b0;
         sign_q     <= 1'b0;
         busy_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         aux_w_q    <= 1'b0;
         done_q     <= 1'b0;
         wb_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         long_q     <= long_d;
         sign_q     <= sign_d;
         busy_q     <= busy_d;
         wb_valid_q <= wb_valid_d;
         aux_w_q    <= aux_w_d;
         done_q     <= done_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign bus.Busy    = busy_q;
   assign bus.WbValid = wb_valid_q;
   assign bus.AuxW    = aux_w_q;
   assign bus.Done    = done_q;
   assign bus.WbData  = wb_data_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: a cycle-timeline model of the operation checked every cycle,
// plus directed operations with hand-computed products, latency, flush and reset cases.
module tb_mul_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   mul_sequencer_if bus ();

   mul_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'd0, a};
      eb = s ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   // Model: phase = cycles since the accepting edge (0 = idle); writeback at 33 and 34.
   int          phase = 0;
   logic [63:0] m_prod = 64'd0;
   logic        m_long = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) phase <= 0;
      else if (phase == 0) begin
         if (bus.Start && !bus.Flush) begin
            phase  <= 1;
            m_prod <= ref_prod(bus.SrcA, bus.SrcB, bus.Signed);
            m_long <= bus.Long;
         end
      end else if (bus.Flush) phase <= 0;
      else if (phase == (m_long ? 34 : 33)) phase <= 0;
      else phase <= phase + 1;
   end

   wire        m_busy = (phase != 0);
   wire        m_wbv  = (phase == 33) || (phase == 34);
   wire        m_aux  = (phase == 34);
   wire        m_done = (phase == (m_long ? 34 : 33));
   wire [31:0] m_data = (phase == 33) ? m_prod[31:0] : (phase == 34) ? m_prod[63:32] : 32'd0;

   always @(negedge clk) begin
      chk($sformatf("cycle_ph%0d", phase),
          64'({bus.Busy, bus.WbValid, bus.AuxW, bus.Done, bus.WbData}),
          64'({m_busy, m_wbv, m_aux, m_done, m_data}));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, 64'({bus.Busy, bus.WbValid, bus.AuxW, bus.Done, bus.WbData}), 64'd0);
   endtask

   // One operation; observations are taken in cycle c (c=1 is the first cycle after Start).
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic l, input logic [31:0] e_lo,
                         input logic [31:0] e_hi, input int pulse_cyc, input int flush_cyc,
                         input int exp_wb);
      int lo_cyc = -1, hi_cyc = -1, wb_n = 0, done_n = 0;
      logic [31:0] lo = 32'd0, hi = 32'd0;
      logic busy_after = 1'b1;
      bus.SrcA = a; bus.SrcB = b; bus.Signed = s; bus.Long = l; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         bus.Start = (c == pulse_cyc);
         if (c == pulse_cyc) begin
            bus.SrcA = ~a; bus.SrcB = b + 32'd3; bus.Signed = ~s; bus.Long = ~l;
         end
         bus.Flush = (c == flush_cyc);
         if (bus.WbValid && !bus.AuxW) begin lo_cyc = c; lo = bus.WbData; end
         if (bus.WbValid && bus.AuxW)  begin hi_cyc = c; hi = bus.WbData; end
         if (bus.WbValid) wb_n++;
         if (bus.Done) done_n++;
         if (c == flush_cyc + 1) busy_after = bus.Busy;
         step();
      end
      bus.Start = 1'b0; bus.Flush = 1'b0;
      chk({nm, "_wb_count"}, 64'(wb_n), 64'(exp_wb));
      chk({nm, "_done_count"}, 64'(done_n), 64'((exp_wb == (l ? 2 : 1)) ? 1 : 0));
      if (exp_wb >= 1) begin
         chk({nm, "_lo_cycle"}, 64'(lo_cyc), 64'd33);
         chk({nm, "_lo"}, 64'(lo), 64'(e_lo));
      end
      if (exp_wb == 2) begin
         chk({nm, "_hi_cycle"}, 64'(hi_cyc), 64'd34);
         chk({nm, "_hi"}, 64'(hi), 64'(e_hi));
      end
      if (flush_cyc != 0) chk({nm, "_busy_after_flush"}, 64'(busy_after), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb_seen;
      bus.Start = 1'b0; bus.Signed = 1'b0; bus.Long = 1'b0; bus.Flush = 1'b0;
      bus.SrcA = 32'd0; bus.SrcB = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("in_reset");
      reset = 1'b0;
      step();
      chk_all_zero("after_reset");

      // Start together with Flush in IDLE is ignored.
      bus.Start = 1'b1; bus.Flush = 1'b1; bus.SrcA = 32'd5; bus.SrcB = 32'd5;
      step();
      bus.Start = 1'b0; bus.Flush = 1'b0;
      step();
      chk("start_with_flush_busy", 64'(bus.Busy), 64'd0);

      run_op("u_short", 32'd7, 32'd6, 1'b0, 1'b0, 32'h0000002A, 32'h0, 0, 0, 1);
      run_op("umull_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1,
             32'h00000001, 32'hFFFFFFFE, 0, 0, 2);
      run_op("smull_m1x2", 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1,
             32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 2);
      run_op("smull_min_sq", 32'h80000000, 32'h80000000, 1'b1, 1'b1,
             32'h00000000, 32'h40000000, 0, 0, 2);
      run_op("smull_max_min", 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1,
             32'h80000000, 32'hC0000000, 0, 0, 2);
      run_op("s_short_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 32'hFFFFFFF1, 32'h0, 0, 0, 1);
      run_op("umull_min_x2", 32'h80000000, 32'd2, 1'b0, 1'b1,
             32'h00000000, 32'h00000001, 0, 0, 2);
      run_op("start_in_calc", 32'h00010000, 32'h00010000, 1'b0, 1'b1,
             32'h00000000, 32'h00000001, 10, 0, 2);
      run_op("flush_calc", 32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0, 15, 0);
      run_op("flush_wb_lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1,
             32'h00000001, 32'h0, 0, 33, 1);

      // Asynchronous reset in the middle of CALC (cycle 20).
      bus.SrcA = 32'd9; bus.SrcB = 32'd9; bus.Signed = 1'b0; bus.Long = 1'b1; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      repeat (19) step();
      chk("busy_before_reset", 64'(bus.Busy), 64'd1);
      #2 reset = 1'b1;
      #1 chk_all_zero("async_reset");
      repeat (2) step();
      reset = 1'b0;
      wb_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.WbValid || bus.Busy) wb_seen++;
         step();
      end
      chk("no_activity_after_reset", 64'(wb_seen), 64'd0);
      run_op("after_reset_op", 32'd7, 32'd6, 1'b0, 1'b0, 32'h0000002A, 32'h0, 0, 0, 1);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
